wrf_pkt_dropper_gen: RTL and testbench
======================================

WRF_PKT_DROPPER_GEN -- requirements
Module: wrf_pkt_dropper_gen

Interface
REQ-001 SHALL have generic g_data_width, default 16, fabric data width in bits.
REQ-002 SHALL have generic g_adr_width, default 2, fabric address width.
REQ-003 SHALL have generic g_pattern_len, default 32, range 1..32, drop-pattern length in frames.
REQ-004 SHALL have generic g_cnt_width, default 32, range 8..32, statistics counter width.
REQ-005 SHALL have ports clk_i in 1, the single clock; rst_n_i in 1, asynchronous active-low reset.
REQ-006 SHALL have snk_cyc, snk_stb, snk_we in 1 each; snk_sel in g_data_width/8; snk_adr in g_adr_width; snk_dat in g_data_width; snk_ack, snk_stall out 1 each: the pipelined fabric sink.
REQ-007 SHALL have src_cyc, src_stb, src_we out 1 each; src_sel out g_data_width/8; src_adr out g_adr_width; src_dat out g_data_width; src_ack, src_stall in 1 each: the fabric source.
REQ-008 SHALL have wb_cyc, wb_stb, wb_we in 1 each; wb_adr in 3 (word address); wb_sel in 4; wb_dat_i in 32; wb_dat_o out 32; wb_ack, wb_stall out 1 each: the control slave.

Function
REQ-009 Registers: 0 CTRL (bit0 EN, bits3:1 MODE, bit4 CLR self-clearing, bit5 ARM self-clearing); 1 PARAM (bits15:0 N, bits31:16 K); 2 PATTERN (bits g_pattern_len-1:0); 3 RX_CNT, 4 DROP_CNT, 5 FWD_CNT (read-only, zero-extended); 6..7 read 0.
REQ-010 Control slave SHALL ack one cycle after cyc&stb, never stall; wb_dat_o is valid with ack.
REQ-011 MODE: 0 PASS; 1 DROP_ONE; 2 EVERY_N; 3 PATTERN; 4 BURST; 5..7 behave as PASS.
REQ-012 FSM states IDLE, FWD, DROP; IDLE->FWD or IDLE->DROP in the cycle after snk_cyc is seen high in IDLE; FWD/DROP->IDLE in the cycle after snk_cyc is seen low.
REQ-013 In IDLE, snk_stall=1, snk_ack=0, src_cyc=0, src_stb=0.
REQ-014 In FWD, all src_* SHALL equal the snk_* inputs combinationally, and snk_ack=src_ack, snk_stall=src_stall.
REQ-015 In DROP, src_cyc=src_stb=0, snk_stall=0, and snk_ack SHALL be a registered copy of snk_cyc&snk_stb (one cycle later).
REQ-016 Drop decision SHALL be taken at the IDLE exit, using frame index F (the RX_CNT value before increment) and registers sampled then; later register writes affect only later frames.
REQ-017 Decision: EN=0 -> forward; PASS -> forward; DROP_ONE -> drop if armed, then disarm; EVERY_N -> drop if N!=0 and F mod N = N-1; PATTERN -> drop if PATTERN bit (F mod g_pattern_len) = 1; BURST -> drop while the burst remaining count is nonzero, decrementing it once per dropped frame.
REQ-018 Writing ARM=1 SHALL set the DROP_ONE armed flag and load the burst remaining count with K; K=0 means no burst drop.
REQ-019 RX_CNT SHALL increment on every IDLE exit; DROP_CNT on each exit to DROP; FWD_CNT on each exit to FWD; all SHALL wrap modulo 2^g_cnt_width.
REQ-020 CLR=1 SHALL zero all counters and the modulo frame index in the same cycle; a simultaneous IDLE exit SHALL be ignored for counting.
REQ-021 EVERY_N/PATTERN frame index SHALL be a separate modulo counter, so that it is not affected by RX_CNT wrap.

Reset
REQ-022 rst_n_i low SHALL force IDLE, all registers and counters to 0, armed flag and burst count to 0, and wb_ack=snk_ack=0; src_cyc=0 immediately; this SHALL also apply mid-frame.
REQ-023 A frame in progress at reset release SHALL be handled from IDLE as a new frame.

Structure
REQ-024 Register addresses, field offsets, mode encodings and the FSM state type SHALL live in shared package wrf_dropper_pkg.
REQ-025 The control slave SHALL be sub-module wrf_dropper_regs; the FSM and datapath SHALL be in the top module.

Verification
REQ-026 EN=1, MODE=2, N=3, 9 frames -> frames 2,5,8 dropped; RX=9, DROP=3, FWD=6.
REQ-027 MODE=3, PATTERN=0x5, g_pattern_len=4, 8 frames -> frames 0,2,4,6 dropped; absorbed frames are acked one cycle after each stb, with src_cyc low.
REQ-028 MODE=4, K=2, ARM, 5 frames -> frames 0,1 dropped and 2..4 forwarded; MODE=1, ARM, 2 frames -> only the first is dropped.
REQ-029 Forwarded frame with random src_stall -> data matches sink word-for-word; snk_stall mirrors src_stall.
REQ-030 Assert rst_n_i mid-forwarded frame -> src_cyc=0 at once; counters read 0; the next frame is counted as F=0.
REQ-031 With g_cnt_width=8, 257 frames then CLR written concurrently with a frame start -> RX reads 1 before CLR and 0 after.

Source files
------------

// File: rtl/wrf_dropper_pkg.sv
// Shared definitions for the fabric packet dropper: register map, control
// field offsets, drop-mode encodings and the frame FSM state type.
package wrf_dropper_pkg;

  localparam logic [2:0] ADR_CTRL     = 3'd0;
  localparam logic [2:0] ADR_PARAM    = 3'd1;
  localparam logic [2:0] ADR_PATTERN  = 3'd2;
  localparam logic [2:0] ADR_RX_CNT   = 3'd3;
  localparam logic [2:0] ADR_DROP_CNT = 3'd4;
  localparam logic [2:0] ADR_FWD_CNT  = 3'd5;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 3;
  localparam int CTRL_CLR_BIT  = 4;
  localparam int CTRL_ARM_BIT  = 5;

  localparam int PARAM_N_LSB = 0;
  localparam int PARAM_K_LSB = 16;

  typedef enum logic [2:0] {
    MODE_PASS     = 3'd0,
    MODE_DROP_ONE = 3'd1,
    MODE_EVERY_N  = 3'd2,
    MODE_PATTERN  = 3'd3,
    MODE_BURST    = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/wrf_dropper_regs.sv
// Control slave for the packet dropper: configuration registers, self-clearing
// CLR/ARM strobes and read-back of the statistics counters.
module wrf_dropper_regs
  import wrf_dropper_pkg::*;
#(
  parameter int g_pattern_len = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wb_cyc,
  input  logic                     wb_stb,
  input  logic                     wb_we,
  input  logic [2:0]               wb_adr,
  input  logic [3:0]               wb_sel,
  input  logic [31:0]              wb_dat_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack,
  output logic                     wb_stall,
  input  logic [31:0]              rx_cnt_i,
  input  logic [31:0]              drop_cnt_i,
  input  logic [31:0]              fwd_cnt_i,
  output logic                     en_o,
  output logic [2:0]               mode_o,
  output logic [15:0]              n_o,
  output logic [15:0]              k_o,
  output logic [g_pattern_len-1:0] pattern_o,
  output logic                     clr_o,
  output logic                     arm_o
);

  logic                     en_q, en_d;
  logic [2:0]               mode_q, mode_d;
  logic [31:0]              param_q, param_d;
  logic [g_pattern_len-1:0] pattern_q, pattern_d;
  logic                     ack_q, ack_d;
  logic [31:0]              dat_q, dat_d;
  logic [31:0]              wmask;
  logic [31:0]              rdata;
  logic                     acc;

  always_comb begin
    acc       = wb_cyc & wb_stb;
    wmask     = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
    en_d      = en_q;
    mode_d    = mode_q;
    param_d   = param_q;
    pattern_d = pattern_q;
    clr_o     = 1'b0;
    arm_o     = 1'b0;
    // CLR/ARM act in the same cycle as the write strobe and are never stored.
    if (acc && wb_we) begin
      case (wb_adr)
        ADR_CTRL: begin
          if (wb_sel[0]) begin
            en_d   = wb_dat_i[CTRL_EN_BIT];
            mode_d = wb_dat_i[CTRL_MODE_MSB:CTRL_MODE_LSB];
            clr_o  = wb_dat_i[CTRL_CLR_BIT];
            arm_o  = wb_dat_i[CTRL_ARM_BIT];
          end
        end
        ADR_PARAM:   param_d = (param_q & ~wmask) | (wb_dat_i & wmask);
        ADR_PATTERN: pattern_d = (pattern_q & ~wmask[g_pattern_len-1:0])
                               | (wb_dat_i[g_pattern_len-1:0] & wmask[g_pattern_len-1:0]);
        default: ;
      endcase
    end

    case (wb_adr)
      ADR_CTRL:     rdata = {28'd0, mode_q, en_q};
      ADR_PARAM:    rdata = param_q;
      ADR_PATTERN:  rdata = 32'(pattern_q);
      ADR_RX_CNT:   rdata = rx_cnt_i;
      ADR_DROP_CNT: rdata = drop_cnt_i;
      ADR_FWD_CNT:  rdata = fwd_cnt_i;
      default:      rdata = 32'd0;
    endcase

    ack_d = acc;
    dat_d = acc ? rdata : dat_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q      <= 1'b0;
      mode_q    <= 3'd0;
      param_q   <= 32'd0;
      pattern_q <= '0;
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      param_q   <= param_d;
      pattern_q <= pattern_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign wb_ack    = ack_q;
  assign wb_dat_o  = dat_q;
  assign wb_stall  = 1'b0;
  assign en_o      = en_q;
  assign mode_o    = mode_q;
  assign n_o       = param_q[PARAM_N_LSB +: 16];
  assign k_o       = param_q[PARAM_K_LSB +: 16];
  assign pattern_o = pattern_q;

endmodule

// File: rtl/wrf_pkt_dropper_gen.sv
// Fabric packet dropper: per-frame forward/drop decision taken when a frame
// starts, transparent forwarding or local absorption, plus statistics.
module wrf_pkt_dropper_gen
  import wrf_dropper_pkg::*;
#(
  parameter int g_data_width  = 16,
  parameter int g_adr_width   = 2,
  parameter int g_pattern_len = 32,
  parameter int g_cnt_width   = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      snk_cyc,
  input  logic                      snk_stb,
  input  logic                      snk_we,
  input  logic [g_data_width/8-1:0] snk_sel,
  input  logic [g_adr_width-1:0]    snk_adr,
  input  logic [g_data_width-1:0]   snk_dat,
  output logic                      snk_ack,
  output logic                      snk_stall,
  output logic                      src_cyc,
  output logic                      src_stb,
  output logic                      src_we,
  output logic [g_data_width/8-1:0] src_sel,
  output logic [g_adr_width-1:0]    src_adr,
  output logic [g_data_width-1:0]   src_dat,
  input  logic                      src_ack,
  input  logic                      src_stall,
  input  logic                      wb_cyc,
  input  logic                      wb_stb,
  input  logic                      wb_we,
  input  logic [2:0]                wb_adr,
  input  logic [3:0]                wb_sel,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack,
  output logic                      wb_stall
);

  localparam int PIDX_W = (g_pattern_len > 1) ? $clog2(g_pattern_len) : 1;
  localparam logic [PIDX_W-1:0]      PIDX_LAST = PIDX_W'(g_pattern_len - 1);
  localparam logic [PIDX_W-1:0]      PIDX_ONE  = PIDX_W'(1);
  localparam logic [g_cnt_width-1:0] CNT_ONE   = g_cnt_width'(1);

  logic                     en;
  logic [2:0]               mode;
  logic [15:0]              n_val, k_val;
  logic [g_pattern_len-1:0] pattern;
  logic                     clr, arm;

  state_e                   state_q, state_d;
  logic                     drop_ack_q, drop_ack_d;
  logic [g_cnt_width-1:0]   rx_cnt_q, rx_cnt_d;
  logic [g_cnt_width-1:0]   drop_cnt_q, drop_cnt_d;
  logic [g_cnt_width-1:0]   fwd_cnt_q, fwd_cnt_d;
  logic [15:0]              modn_q, modn_d;
  logic [PIDX_W-1:0]        pidx_q, pidx_d;
  logic                     armed_q, armed_d;
  logic [15:0]              burst_q, burst_d;
  logic                     drop_dec;
  logic                     frame_exit;

  wrf_dropper_regs #(
    .g_pattern_len(g_pattern_len)
  ) u_regs (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_sel     (wb_sel),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack     (wb_ack),
    .wb_stall   (wb_stall),
    .rx_cnt_i   (32'(rx_cnt_q)),
    .drop_cnt_i (32'(drop_cnt_q)),
    .fwd_cnt_i  (32'(fwd_cnt_q)),
    .en_o       (en),
    .mode_o     (mode),
    .n_o        (n_val),
    .k_o        (k_val),
    .pattern_o  (pattern),
    .clr_o      (clr),
    .arm_o      (arm)
  );

  // Drop decision for the frame starting now; modn_q/pidx_q are the frame
  // index reduced modulo N and modulo the pattern length.
  always_comb begin
    drop_dec = 1'b0;
    if (en) begin
      case (mode)
        MODE_DROP_ONE: drop_dec = armed_q;
        MODE_EVERY_N:  drop_dec = (n_val != 16'd0) && (modn_q == n_val - 16'd1);
        MODE_PATTERN:  drop_dec = pattern[pidx_q];
        MODE_BURST:    drop_dec = (burst_q != 16'd0);
        default:       drop_dec = 1'b0;
      endcase
    end
  end

  assign frame_exit = (state_q == ST_IDLE) && snk_cyc;

  always_comb begin
    state_d    = state_q;
    drop_ack_d = 1'b0;
    src_cyc    = 1'b0;
    src_stb    = 1'b0;
    src_we     = snk_we;
    src_sel    = snk_sel;
    src_adr    = snk_adr;
    src_dat    = snk_dat;
    snk_ack    = 1'b0;
    snk_stall  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (snk_cyc) state_d = drop_dec ? ST_DROP : ST_FWD;
      end
      ST_FWD: begin
        src_cyc   = snk_cyc;
        src_stb   = snk_stb;
        snk_ack   = src_ack;
        snk_stall = src_stall;
        if (!snk_cyc) state_d = ST_IDLE;
      end
      ST_DROP: begin
        snk_stall  = 1'b0;
        snk_ack    = drop_ack_q;
        drop_ack_d = snk_cyc & snk_stb;
        if (!snk_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fwd_cnt_d  = fwd_cnt_q;
    modn_d     = modn_q;
    pidx_d     = pidx_q;
    armed_d    = armed_q;
    burst_d    = burst_q;
    // CLR wins over a frame start in the same cycle; that frame goes uncounted.
    if (clr) begin
      rx_cnt_d   = '0;
      drop_cnt_d = '0;
      fwd_cnt_d  = '0;
      modn_d     = 16'd0;
      pidx_d     = '0;
    end else if (frame_exit) begin
      rx_cnt_d = rx_cnt_q + CNT_ONE;
      if (drop_dec) drop_cnt_d = drop_cnt_q + CNT_ONE;
      else          fwd_cnt_d  = fwd_cnt_q + CNT_ONE;
      if ((n_val == 16'd0) || (modn_q >= n_val - 16'd1)) modn_d = 16'd0;
      else                                               modn_d = modn_q + 16'd1;
      pidx_d = (pidx_q == PIDX_LAST) ? '0 : pidx_q + PIDX_ONE;
    end
    if (arm) begin
      armed_d = 1'b1;
      burst_d = k_val;
    end else if (frame_exit && en) begin
      if (mode == MODE_DROP_ONE) armed_d = 1'b0;
      if ((mode == MODE_BURST) && (burst_q != 16'd0)) burst_d = burst_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      drop_ack_q <= 1'b0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      fwd_cnt_q  <= '0;
      modn_q     <= 16'd0;
      pidx_q     <= '0;
      armed_q    <= 1'b0;
      burst_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      drop_ack_q <= drop_ack_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fwd_cnt_q  <= fwd_cnt_d;
      modn_q     <= modn_d;
      pidx_q     <= pidx_d;
      armed_q    <= armed_d;
      burst_q    <= burst_d;
    end
  end

endmodule

// File: tb/tb_wrf_pkt_dropper_gen.sv
// Directed bench for wrf_pkt_dropper_gen: drop modes, absorbed-frame acks,
// forwarding under source stall, reset mid-frame and counter wrap/clear.
module tb_wrf_pkt_dropper_gen;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int PL = 4;
  localparam int CW = 8;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          snk_cyc = 1'b0, snk_stb = 1'b0, snk_we = 1'b0;
  logic [SW-1:0] snk_sel = '0;
  logic [AW-1:0] snk_adr = '0;
  logic [DW-1:0] snk_dat = '0;
  logic          snk_ack, snk_stall;
  logic          src_cyc, src_stb, src_we;
  logic [SW-1:0] src_sel;
  logic [AW-1:0] src_adr;
  logic [DW-1:0] src_dat;
  logic          src_ack = 1'b0, src_stall = 1'b0;
  logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [2:0]    wb_adr = '0;
  logic [3:0]    wb_sel = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack, wb_stall;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_q[$];
  logic stall_rand = 1'b0;
  logic slave_acc = 1'b0;

  always #5 clk = ~clk;

  wrf_pkt_dropper_gen #(
    .g_data_width(DW), .g_adr_width(AW), .g_pattern_len(PL), .g_cnt_width(CW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .snk_cyc(snk_cyc), .snk_stb(snk_stb), .snk_we(snk_we), .snk_sel(snk_sel),
    .snk_adr(snk_adr), .snk_dat(snk_dat), .snk_ack(snk_ack), .snk_stall(snk_stall),
    .src_cyc(src_cyc), .src_stb(src_stb), .src_we(src_we), .src_sel(src_sel),
    .src_adr(src_adr), .src_dat(src_dat), .src_ack(src_ack), .src_stall(src_stall),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .wb_stall(wb_stall)
  );

  // Source-side slave: accepts when stb & !stall, acks one cycle later.
  always @(negedge clk) begin
    slave_acc = src_cyc & src_stb & ~src_stall;
    if (slave_acc) rx_q.push_back(src_dat);
  end

  always @(posedge clk) begin
    #1;
    src_ack   = slave_acc;
    src_stall = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat_i = dat; wb_sel = 4'hF;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] adr, output logic [31:0] dat, output logic ack);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr; wb_sel = 4'hF;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    #1;
    ack = wb_ack;
    dat = wb_dat_o;
  endtask

  task automatic send_frame(input int nw, input logic [DW-1:0] base, output logic fwd_seen,
                            output int acks, output int ack_err, output int mirror_err,
                            output logic done);
    int idx;
    logic prev_acc, acc;
    idx = 0; prev_acc = 1'b0; fwd_seen = 1'b0; acks = 0; ack_err = 0; mirror_err = 0; done = 1'b0;
    @(posedge clk); #1;
    snk_cyc = 1'b1; snk_we = 1'b1; snk_sel = '1;
    for (int c = 0; c < 400; c++) begin
      if (idx < nw) begin
        snk_stb = 1'b1; snk_dat = base + DW'(idx); snk_adr = AW'(idx);
      end else begin
        snk_stb = 1'b0;
      end
      #1;
      if (src_cyc) begin
        fwd_seen = 1'b1;
        if (snk_stall !== src_stall || snk_ack !== src_ack) mirror_err++;
      end else if (!snk_stall) begin
        if (snk_ack !== prev_acc) ack_err++;
      end
      if (snk_ack === 1'b1) acks++;
      acc = snk_stb & ~snk_stall;
      if (acc) idx++;
      prev_acc = acc;
      if (idx >= nw && acks >= nw) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    snk_stb = 1'b0; snk_cyc = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic a;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (src_cyc !== 1'b0 || snk_stall !== 1'b1 || snk_ack !== 1'b0 || wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: src_cyc=%b snk_stall=%b snk_ack=%b wb_ack=%b, required 0 1 0 0",
               src_cyc, snk_stall, snk_ack, wb_ack);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 6; r++) begin
      wb_read(3'(r), d, a);
      checks++;
      if (a !== 1'b1 || d !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: ack=%b data=%h, required ack=1 data=00000000", r, a, d);
      end
    end
  endtask

  task automatic test_wb_regs();
    logic [31:0] d;
    logic a;
    wb_write(3'd1, 32'h0002_0003);
    wb_read(3'd1, d, a);
    checks++;
    if (a !== 1'b1 || d !== 32'h0002_0003) begin
      errors++; $display("FAIL param_rb: ack=%b data=%h, required 1 00020003", a, d);
    end
    wb_write(3'd2, 32'hFFFF_FFF5);
    wb_read(3'd2, d, a);
    checks++;
    if (d !== 32'h0000_0005) begin
      errors++; $display("FAIL pattern_rb: data=%h, required 00000005", d);
    end
    wb_write(3'd0, 32'h0000_0035);
    wb_read(3'd0, d, a);
    checks++;
    if (d !== 32'h0000_0005) begin
      errors++; $display("FAIL ctrl_rb: data=%h, required 00000005", d);
    end
    wb_read(3'd6, d, a);
    checks++;
    if (a !== 1'b1 || d !== 32'd0) begin
      errors++; $display("FAIL reg6_rb: ack=%b data=%h, required 1 00000000", a, d);
    end
    checks++;
    if (wb_stall !== 1'b0) begin
      errors++; $display("FAIL wb_stall: got %b, required 0", wb_stall);
    end
  endtask

  task automatic check_counters(input string tag, input logic [31:0] rx, input logic [31:0] dr,
                                input logic [31:0] fw);
    logic [31:0] d;
    logic a;
    wb_read(3'd3, d, a);
    checks++;
    if (d !== rx) begin errors++; $display("FAIL %s_rx: got %0d, required %0d", tag, d, rx); end
    wb_read(3'd4, d, a);
    checks++;
    if (d !== dr) begin errors++; $display("FAIL %s_drop: got %0d, required %0d", tag, d, dr); end
    wb_read(3'd5, d, a);
    checks++;
    if (d !== fw) begin errors++; $display("FAIL %s_fwd: got %0d, required %0d", tag, d, fw); end
  endtask

  task automatic test_every_n();
    logic fwd, done, exp_fwd;
    int acks, aerr, merr;
    wb_write(3'd1, 32'h0000_0003);
    wb_write(3'd0, 32'h0000_0015);
    for (int f = 0; f < 9; f++) begin
      exp_fwd = ((f % 3) != 2);
      send_frame(2, 16'h1000 + 16'(f * 16), fwd, acks, aerr, merr, done);
      checks++;
      if (!done || fwd !== exp_fwd || acks != 2) begin
        errors++;
        $display("FAIL every_n_frame%0d: done=%b fwd=%b acks=%0d, required done=1 fwd=%b acks=2",
                 f, done, fwd, acks, exp_fwd);
      end
    end
    check_counters("every_n", 32'd9, 32'd3, 32'd6);
  endtask

  task automatic test_pattern();
    logic fwd, done, exp_fwd;
    logic [3:0] pat;
    int acks, aerr, merr;
    pat = 4'h5;
    wb_write(3'd2, 32'h0000_0005);
    wb_write(3'd0, 32'h0000_0017);
    for (int f = 0; f < 8; f++) begin
      exp_fwd = ~pat[f % 4];
      send_frame(3, 16'h2000 + 16'(f * 16), fwd, acks, aerr, merr, done);
      checks++;
      if (!done || fwd !== exp_fwd || acks != 3 || aerr != 0) begin
        errors++;
        $display("FAIL pattern_frame%0d: done=%b fwd=%b acks=%0d ack_timing_err=%0d, required 1 %b 3 0",
                 f, done, fwd, acks, aerr, exp_fwd);
      end
    end
    check_counters("pattern", 32'd8, 32'd4, 32'd4);
  endtask

  task automatic test_burst_and_drop_one();
    logic fwd, done, exp_fwd;
    int acks, aerr, merr;
    wb_write(3'd1, 32'h0002_0000);
    wb_write(3'd0, 32'h0000_0039);
    for (int f = 0; f < 5; f++) begin
      exp_fwd = (f >= 2);
      send_frame(2, 16'h3000, fwd, acks, aerr, merr, done);
      checks++;
      if (!done || fwd !== exp_fwd || aerr != 0) begin
        errors++;
        $display("FAIL burst_frame%0d: done=%b fwd=%b ack_timing_err=%0d, required 1 %b 0",
                 f, done, fwd, aerr, exp_fwd);
      end
    end
    wb_write(3'd0, 32'h0000_0023);
    for (int f = 0; f < 2; f++) begin
      exp_fwd = (f != 0);
      send_frame(2, 16'h3100, fwd, acks, aerr, merr, done);
      checks++;
      if (!done || fwd !== exp_fwd) begin
        errors++;
        $display("FAIL drop_one_frame%0d: done=%b fwd=%b, required 1 %b", f, done, fwd, exp_fwd);
      end
    end
  endtask

  task automatic test_stall_forward();
    logic fwd, done;
    int acks, aerr, merr;
    wb_write(3'd0, 32'h0000_0011);
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'hA000 + 16'(i));
    stall_rand = 1'b1;
    send_frame(8, 16'hA000, fwd, acks, aerr, merr, done);
    stall_rand = 1'b0;
    checks++;
    if (!done || fwd !== 1'b1 || acks != 8 || merr != 0) begin
      errors++;
      $display("FAIL stall_frame: done=%b fwd=%b acks=%0d mirror_err=%0d, required 1 1 8 0",
               done, fwd, acks, merr);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_word_count: got %0d, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stall_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    check_counters("stall", 32'd1, 32'd0, 32'd1);
  endtask

  task automatic test_reset_mid_frame();
    logic fwd, done, seen;
    int acks, aerr, merr;
    seen = 1'b0;
    wb_write(3'd0, 32'h0000_0001);
    @(posedge clk); #1;
    snk_cyc = 1'b1; snk_stb = 1'b1; snk_dat = 16'h1234;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (src_cyc === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_fwd_start: src_cyc=0, required 1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (src_cyc !== 1'b0 || snk_ack !== 1'b0 || snk_stall !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs: src_cyc=%b snk_ack=%b snk_stall=%b, required 0 0 1",
               src_cyc, snk_ack, snk_stall);
    end
    snk_cyc = 1'b0; snk_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_counters("midrst", 32'd0, 32'd0, 32'd0);
    wb_write(3'd2, 32'h0000_0001);
    wb_write(3'd0, 32'h0000_0007);
    send_frame(2, 16'h4000, fwd, acks, aerr, merr, done);
    checks++;
    if (!done || fwd !== 1'b0) begin
      errors++; $display("FAIL midrst_first_frame: done=%b fwd=%b, required 1 0", done, fwd);
    end
    check_counters("midrst_after", 32'd1, 32'd1, 32'd0);
  endtask

  task automatic test_cnt_wrap_clr();
    logic fwd, done;
    int acks, aerr, merr;
    int timeouts;
    timeouts = 0;
    wb_write(3'd0, 32'h0000_0011);
    for (int f = 0; f < 257; f++) begin
      send_frame(1, 16'(f), fwd, acks, aerr, merr, done);
      if (!done) timeouts++;
    end
    checks++;
    if (timeouts != 0) begin
      errors++; $display("FAIL wrap_frames: timeouts=%0d, required 0", timeouts);
    end
    check_counters("wrap", 32'd1, 32'd0, 32'd1);
    @(posedge clk); #1;
    snk_cyc = 1'b1; snk_stb = 1'b1; snk_we = 1'b1; snk_dat = 16'hBEEF;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 3'd0; wb_sel = 4'hF;
    wb_dat_i = 32'h0000_0011;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    snk_stb = 1'b0;
    @(posedge clk); #1;
    snk_cyc = 1'b0;
    repeat (2) @(posedge clk);
    check_counters("clr_concurrent", 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_wb_regs();
    test_every_n();
    test_pattern();
    test_burst_and_drop_one();
    test_stall_forward();
    test_reset_mid_frame();
    test_cnt_wrap_clr();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
